// File: rtl/beat_pingpong_writer_if.sv
// Bundle of producer, control, read and status signals for the ping-pong writer.
// Latency: none, wiring only.
// Backpressure: in_ready from the writer stalls the producer; the held sample must stay on in_data.
interface beat_pingpong_writer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             release_pulse;
  logic             release_bank;
  logic             rd_bank;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             wr_bank;
  logic [1:0]       bank_full;
  logic [CW-1:0]    bank0_count;
  logic [CW-1:0]    bank1_count;

  modport master (
    output in_valid, in_data, flush, release_pulse, release_bank, rd_bank, rd_addr,
    input  in_ready, rd_data, wr_bank, bank_full, bank0_count, bank1_count
  );

  modport slave (
    input  in_valid, in_data, flush, release_pulse, release_bank, rd_bank, rd_addr,
    output in_ready, rd_data, wr_bank, bank_full, bank0_count, bank1_count
  );
endinterface

// File: rtl/beat_pingpong_writer.sv
// Two-bank ping-pong sample writer: fills one bank while the other is held for a consumer.
// Latency: accepted sample is readable from the next cycle; rd_data is registered, 1 cycle after rd_addr.
// Backpressure: in_ready drops (registered state) while the next bank to fill is still committed.
module beat_pingpong_writer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  beat_pingpong_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {S_FILL = 1'b0, S_WAIT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_wr_ptr, w_wr_ptr_nxt;
  logic             r_wr_bank, w_wr_bank_nxt;
  logic [1:0]       r_bank_full, w_bank_full_nxt, w_full_rel;
  logic [CW-1:0]    r_count0, r_count1, w_count0_nxt, w_count1_nxt;
  logic [CW-1:0]    w_commit_cnt;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_mem [2][DEPTH];
  logic             w_accept, w_commit, w_rel0, w_rel1;

  // Next-state decode: release is applied first, then any commit, then the FILL/WAIT decision.
  always_comb begin
    w_accept     = bus.in_valid && (r_state == S_FILL);
    // A flush that coincides with the last-slot accept is the same single commit.
    w_commit     = (r_state == S_FILL) &&
                   ((w_accept && (r_wr_ptr == LAST)) ||
                    (bus.flush && (w_accept || (r_wr_ptr != '0))));
    // Covers both full (LAST + 1 = DEPTH) and partial commits.
    w_commit_cnt = CW'(r_wr_ptr) + CW'(w_accept);
    // Releasing a bank that is not committed must leave everything alone.
    w_rel0       = bus.release_pulse && !bus.release_bank && r_bank_full[0];
    w_rel1       = bus.release_pulse &&  bus.release_bank && r_bank_full[1];
    w_full_rel   = r_bank_full & ~{w_rel1, w_rel0};

    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_wr_bank_nxt   = r_wr_bank;
    w_bank_full_nxt = w_full_rel;
    w_count0_nxt    = w_rel0 ? '0 : r_count0;
    w_count1_nxt    = w_rel1 ? '0 : r_count1;

    if (w_accept) begin
      w_wr_ptr_nxt = r_wr_ptr + 1'b1;
    end

    if (w_commit) begin
      w_wr_ptr_nxt               = '0;
      w_wr_bank_nxt              = ~r_wr_bank;
      w_bank_full_nxt[r_wr_bank] = 1'b1;
      if (r_wr_bank) begin
        w_count1_nxt = w_commit_cnt;
      end else begin
        w_count0_nxt = w_commit_cnt;
      end
      if (w_full_rel[~r_wr_bank]) begin
        w_state_nxt = S_WAIT;
      end
    end

    if ((r_state == S_WAIT) && !w_full_rel[r_wr_bank]) begin
      w_state_nxt = S_FILL;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write pointer, active bank, committed flags and counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_wr_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_count0    <= '0;
      r_count1    <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_bank_full <= w_bank_full_nxt;
      r_count0    <= w_count0_nxt;
      r_count1    <= w_count1_nxt;
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_bank][r_wr_ptr] <= bus.in_data;
    end
  end

  // Registered read port; a same-cycle write to the same slot is seen next cycle (old data now).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[bus.rd_bank][bus.rd_addr];
    end
  end

  assign bus.in_ready    = (r_state == S_FILL);
  assign bus.rd_data     = r_rd_data;
  assign bus.wr_bank     = r_wr_bank;
  assign bus.bank_full   = r_bank_full;
  assign bus.bank0_count = r_count0;
  assign bus.bank1_count = r_count1;
endmodule

// File: doc/beat_pingpong_writer.md
BEAT_PINGPONG_WRITER -- requirements
Module: beat_pingpong_writer

Interface
REQ-001 Parameter WIDTH, default 8, sample data width in bits.
REQ-002 Parameter DEPTH, default 32, entries per bank; power of two, 2..64.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  producer presents in_data this cycle.
REQ-006 in_data  input  WIDTH  sample to store.
REQ-007 in_ready  output  1  writer accepts a sample this cycle.
REQ-008 flush  input  1  commit the partially filled current bank.
REQ-009 release  input  1  single-cycle pulse; consumer frees one bank.
REQ-010 release_bank  input  1  bank index freed by release.
REQ-011 rd_bank  input  1  bank selected for reading.
REQ-012 rd_addr  input  log2(DEPTH)  entry address for reading.
REQ-013 rd_data  output  WIDTH  registered read data.
REQ-014 wr_bank  output  1  bank currently being filled.
REQ-015 bank_full  output  2  per-bank committed flag; bit n is bank n.
REQ-016 bank0_count, bank1_count  output  log2(DEPTH)+1 each  valid entries in each committed bank.

Function
REQ-017 Storage: two banks of DEPTH x WIDTH; contents are not reset.
REQ-018 States: FILL and WAIT; in_ready SHALL be 1 in FILL and 0 in WAIT, decoded from registered state only.
REQ-019 Accept: in_valid && in_ready writes in_data to bank wr_bank at address wr_ptr, then wr_ptr increments.
REQ-020 Full commit: an accept at wr_ptr == DEPTH-1 sets bank_full[wr_bank] and sets that bank's count to DEPTH; wr_ptr returns to 0 and wr_bank toggles.
REQ-021 Flush commit: in FILL, flush with wr_ptr != 0 commits the bank with count = wr_ptr, or wr_ptr+1 if a sample is accepted in the same cycle; wr_ptr returns to 0 and wr_bank toggles.
REQ-022 Flush is ignored when wr_ptr == 0 and no sample is accepted, or when in WAIT.
REQ-023 Flush coinciding with an accept at DEPTH-1 is a single full commit; it never triggers a second commit.
REQ-024 Release: release clears bank_full[release_bank] and zeroes its count.
REQ-025 Release of a bank whose bank_full bit is 0 has no effect.
REQ-026 Transitions:
- FILL -> WAIT: a commit toggles wr_bank onto a bank whose bank_full bit is 1 after this cycle's release is applied.
- WAIT -> FILL: on the cycle after bank_full[wr_bank] clears.
REQ-027 Release and commit in the same cycle: the release is applied first; the state decision uses the post-release flags.
REQ-028 Read: rd_data <= bank[rd_bank][rd_addr] every cycle, giving 1-cycle latency independent of state.
REQ-029 Read/write collision: a read and a write to the same bank and address in one cycle returns the old contents; there is no bypass.
REQ-030 Producer rule: in_data is sampled only on an accept; a held sample in WAIT is not lost.

Reset
REQ-031 While reset is high, with immediate (asynchronous) effect:
- state = FILL, wr_ptr = 0, wr_bank = 0, bank_full = 2'b00, both counts = 0, rd_data = 0.
- in_ready = 1.
REQ-032 Reset asserted mid-fill discards the partial bank; counts restart from 0 after reset deasserts.

Verification
REQ-033 After reset, accept 0..31 on consecutive cycles -> bank_full = 01, bank0_count = 32, wr_bank = 1, in_ready = 1; then rd_bank = 0, rd_addr = 5 -> rd_data = 5 one cycle later.
REQ-034 Accept 64 samples with no release -> in_ready = 0 the cycle after the 64th accept, bank_full = 11; sample 65 is held; pulse release, release_bank = 0 -> in_ready = 1 the next cycle; sample 65 is stored at bank0[0].
REQ-035 Accept 7 samples, then flush alone -> bank_full[0] = 1, bank0_count = 7, wr_bank = 1; a later flush with no accept is ignored.
REQ-036 Flush in the same cycle as the 10th accept -> bank0_count = 10; flush with the 32nd accept -> single commit, bank0_count = 32.
REQ-037 Bank 0 full and bank 1 filling; release of bank 0 in the same cycle as bank 1's 32nd accept -> state stays FILL, wr_bank = 0, bank_full = 10; release of empty bank 0 -> no change.
REQ-038 Assert reset asynchronously after 12 accepts -> all outputs take reset values before the next clock edge; in_ready = 1.
